// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: activations stream in one per beat, N_OUT MAC lanes
// accumulate them against a writable weight/bias file, then rescale, saturate and optionally ReLU.
module dense_layer_seq #(
    parameter int unsigned N_IN  = 32,
    parameter int unsigned N_OUT = 5,
    parameter int unsigned WIDTH = 13,
    parameter int unsigned NFRAC = 6,
    localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   act_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    input  logic                   wr_en,
    input  logic                   wr_is_bias,
    input  logic [IW-1:0]          wr_in,
    input  logic [OW-1:0]          wr_out,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   busy
);

    localparam int unsigned AW = 2 * WIDTH + IW + 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic signed [AW-1:0] SatMax = AW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [AW-1:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic mode_q, mode_d;
    logic signed [AW-1:0] acc_q [N_OUT];
    logic signed [AW-1:0] acc_d [N_OUT];
    logic signed [WIDTH-1:0] weight_q [N_IN][N_OUT];
    logic signed [WIDTH-1:0] bias_q [N_OUT];
    logic [N_OUT*WIDTH-1:0] out_q, out_d;
    logic signed [PW-1:0] prod [N_OUT];
    logic [IW-1:0] rd_row;
    logic beat;
    logic last_beat;
    logic wr_ok;

    // Rescale by NFRAC (floor), clamp to the WIDTH-bit range, then optional ReLU.
    function automatic logic [WIDTH-1:0] saturate(input logic signed [AW-1:0] a,
                                                  input logic relu);
        logic signed [AW-1:0] r;
        logic [WIDTH-1:0] s;
        r = a >>> NFRAC;
        if (r > SatMax) begin
            s = SatMax[WIDTH-1:0];
        end else if (r < SatMin) begin
            s = SatMin[WIDTH-1:0];
        end else begin
            s = r[WIDTH-1:0];
        end
        if (relu && s[WIDTH-1]) begin
            s = '0;
        end
        return s;
    endfunction

    assign in_ready  = (state_q != StDone);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_q;

    assign beat      = in_valid & in_ready;
    assign rd_row    = (state_q == StAccum) ? cnt_q : '0;
    assign last_beat = (state_q == StIdle) ? (N_IN == 1) : (cnt_q == IW'(N_IN - 1));

    // A write landing in the same cycle as a beat (or outside IDLE) is dropped.
    assign wr_ok = wr_en && (state_q == StIdle) && !in_valid
                   && (32'(wr_in) < N_IN) && (32'(wr_out) < N_OUT);

    always_comb begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            prod[j] = PW'(weight_q[rd_row][j]) * PW'($signed(in_data));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            acc_d[j] = acc_q[j];
        end

        unique case (state_q)
            StIdle: begin
                if (beat) begin
                    mode_d = act_mode;
                    cnt_d  = IW'(1);
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        acc_d[j] = (AW'(bias_q[j]) <<< NFRAC) + AW'(prod[j]);
                    end
                    state_d = last_beat ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (beat) begin
                    cnt_d = cnt_q + IW'(1);
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        acc_d[j] = acc_q[j] + AW'(prod[j]);
                    end
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Results are captured once, on entry to DONE, and held until the handshake.
        if (state_d == StDone && state_q != StDone) begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                out_d[j*WIDTH +: WIDTH] = saturate(acc_d[j], mode_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                acc_q[j]  <= '0;
                bias_q[j] <= '0;
                for (int unsigned i = 0; i < N_IN; i++) begin
                    weight_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                acc_q[j] <= acc_d[j];
            end
            if (wr_ok) begin
                if (wr_is_bias) begin
                    bias_q[wr_out] <= wr_data;
                end else begin
                    weight_q[wr_in][wr_out] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Randomised self-checking bench for dense_layer_seq against a plain-arithmetic layer model.
module tb_dense_layer_seq;

    localparam int N_IN  = 32;
    localparam int N_OUT = 5;
    localparam int WIDTH = 13;
    localparam int NFRAC = 6;

    logic                   clk;
    logic                   rst_n;
    logic                   act_mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   wr_en;
    logic                   wr_is_bias;
    logic [4:0]             wr_in;
    logic [2:0]             wr_out;
    logic [WIDTH-1:0]       wr_data;
    logic                   busy;

    dense_layer_seq #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .WIDTH(WIDTH),
        .NFRAC(NFRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_mode  (act_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .wr_en     (wr_en),
        .wr_is_bias(wr_is_bias),
        .wr_in     (wr_in),
        .wr_out    (wr_out),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int w[N_IN][N_OUT];
    int b[N_OUT];
    int x[N_IN];
    bit cur_mode;
    longint last_out[N_OUT];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Layer output from the arithmetic definition: floor(sum/2^NFRAC), clamp, optional ReLU.
    function automatic longint model_lane(int j, bit mode);
        longint acc;
        longint r;
        acc = longint'(b[j]) * 64;
        for (int i = 0; i < N_IN; i++) acc += longint'(w[i][j]) * longint'(x[i]);
        r = acc >>> NFRAC;
        if (r > 4095) r = 4095;
        if (r < -4096) r = -4096;
        if (mode && r < 0) r = 0;
        return r;
    endfunction

    task automatic clear_model();
        for (int j = 0; j < N_OUT; j++) begin
            b[j] = 0;
            for (int i = 0; i < N_IN; i++) w[i][j] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    // Called only in idle IDLE, so a valid write is expected to land.
    task automatic write_coef(input bit is_bias, input int row, input int lane, input int val);
        wr_en = 1'b1; wr_is_bias = is_bias; wr_in = 5'(row); wr_out = 3'(lane);
        wr_data = WIDTH'(val);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (lane < N_OUT) begin
            if (is_bias) b[lane] = val;
            else w[row][lane] = val;
        end
    endtask

    task automatic drive_w5_write();
        wr_en = 1'b1; wr_is_bias = 1'b0; wr_in = 5'd5; wr_out = 3'd0; wr_data = WIDTH'(127);
    endtask

    task automatic stream(input int n, input bit mode, input bit gaps,
                          input bit wr_first, input bit wr_mid);
        cur_mode = mode;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (wr_mid && i == 5) begin
                in_valid = 1'b0;
                drive_w5_write();
                @(posedge clk); #1;
                wr_en = 1'b0;
            end
            check("in_ready_beat", in_ready, 1);
            in_valid = 1'b1;
            in_data  = WIDTH'(x[i]);
            act_mode = (i == 0) ? mode : 1'($urandom);
            if ((wr_first && i == 0) || (wr_mid && i == 5)) drive_w5_write();
            @(posedge clk); #1;
            wr_en = 1'b0;
            if (i < N_IN - 1) check("no_early_valid", out_valid, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int bp);
        logic [N_OUT*WIDTH-1:0] snap;
        logic signed [WIDTH-1:0] s;
        check("out_valid_latency", out_valid, 1);
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        snap = out_data;
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; in_data = WIDTH'($urandom);
            // Bias write attempted in DONE must be dropped.
            wr_en = 1'b1; wr_is_bias = 1'b1; wr_in = 5'd0; wr_out = 3'd1; wr_data = WIDTH'(77);
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", longint'(out_data == snap), 1);
        end
        in_valid = 1'b0; wr_en = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin
            s = out_data[j*WIDTH +: WIDTH];
            last_out[j] = longint'(s);
            check($sformatf("lane%0d", j), last_out[j], model_lane(j, cur_mode));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; act_mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        wr_en = 1'b0; wr_is_bias = 1'b0; wr_in = '0; wr_out = '0; wr_data = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", longint'(out_data == '0), 1);

        // Unit weights on lane 0, bias -1/16.
        for (int i = 0; i < N_IN; i++) write_coef(0, i, 0, 64);
        write_coef(1, 0, 0, -4);
        for (int i = 0; i < N_IN; i++) x[i] = 64;
        stream(N_IN, 0, 0, 0, 0);
        collect(3);
        check("unit_lane0", last_out[0], 2044);

        // Floor rounding.
        do_reset();
        write_coef(0, 0, 1, 1);
        write_coef(0, 0, 2, -1);
        for (int i = 0; i < N_IN; i++) x[i] = (i == 0) ? 1 : 0;
        stream(N_IN, 0, 1, 0, 0);
        collect(0);
        check("round_lane1", last_out[1], 0);
        check("round_lane2", last_out[2], -1);

        // Saturation both ways, then ReLU.
        do_reset();
        for (int i = 0; i < N_IN; i++) write_coef(0, i, 0, 64);
        for (int i = 0; i < N_IN; i++) x[i] = 4095;
        stream(N_IN, 0, 0, 0, 0);
        collect(1);
        check("sat_pos", last_out[0], 4095);
        for (int i = 0; i < N_IN; i++) x[i] = -4096;
        stream(N_IN, 0, 0, 0, 0);
        collect(0);
        check("sat_neg", last_out[0], -4096);
        stream(N_IN, 1, 1, 0, 0);
        collect(2);
        check("relu_neg", last_out[0], 0);

        // Write guard: writes during ACCUM and colliding with the first beat are dropped.
        write_coef(0, 5, 0, 10);
        for (int i = 0; i < N_IN; i++) x[i] = $urandom_range(0, 100) - 50;
        x[5] = 40;
        stream(N_IN, 0, 1, 1, 1);
        collect(0);
        write_coef(0, 5, 0, 127);
        write_coef(0, 3, 5, 999);
        stream(N_IN, 0, 0, 0, 0);
        collect(0);

        // Reset mid-ACCUM aborts and clears the coefficient file.
        for (int i = 0; i < N_IN; i++) x[i] = $urandom_range(0, 8191) - 4096;
        stream(10, 0, 0, 0, 0);
        check("mid_busy", busy, 1);
        do_reset();
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        for (int i = 0; i < N_IN; i++) x[i] = $urandom_range(0, 8191) - 4096;
        stream(N_IN, 0, 0, 0, 0);
        collect(0);
        for (int j = 0; j < N_OUT; j++) check("cleared_lane", last_out[j], 0);

        // Random coefficients, data, mode, gaps and backpressure.
        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < N_OUT; j++) begin
                write_coef(1, 0, j, $urandom_range(0, 8191) - 4096);
                for (int i = 0; i < N_IN; i++) write_coef(0, i, j, $urandom_range(0, 8191) - 4096);
            end
            for (int i = 0; i < N_IN; i++) begin
                x[i] = (t < 6) ? ($urandom_range(0, 255) - 128) : ($urandom_range(0, 8191) - 4096);
            end
            stream(N_IN, 1'($urandom), 1, 1'($urandom), 1'($urandom));
            collect($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
